// File: rtl/rv32_pkg.sv
// Shared RV32I processor definitions: widths, reset vector, address type and
// next-pc source selector.
package rv32_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

    // Next-pc sources; branch and trap sources get appended here later.
    typedef enum logic {
        NPC_SEQ      = 1'b0,
        NPC_REDIRECT = 1'b1
    } next_pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-pc selection for the fetch stage: reset vector,
// word-aligned redirect target, or sequential pc + 4 (wraps modulo 2^XLEN).
module pc_next_mux
    import rv32_pkg::*;
#(
    parameter int unsigned      XLEN     = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(rv32_pkg::RESET_PC)
) (
    input  logic               reset,
    input  next_pc_sel_t       sel,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    target,
    output logic [XLEN-1:0]    next_pc_c
);

    // Reset beats redirect beats sequential; redirect drops the low two bits.
    always_comb begin
        next_pc_c = pc + XLEN'(INSTR_BYTES);
        if (reset) begin
            next_pc_c = RESET_PC;
        end else if (sel == NPC_REDIRECT) begin
            next_pc_c = {target[XLEN-1:2], 2'b00};
        end
    end

endmodule

// File: rtl/rv32_fetch_proc.sv
// Fetch stage of the RV32I pipeline: holds the program counter and drives it
// to the external instruction memory. temp_sel/temp_target is a temporary
// redirect hook until execute-stage branch resolution exists.
// Optional build macro FETCH_TRACE_EN adds internal fetch/redirect counters
// and a simulation trace line per non-reset edge; no ports change.
module rv32_fetch_proc
    import rv32_pkg::*;
#(
    parameter int unsigned      XLEN     = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(rv32_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    pc,
    input  logic               temp_sel,
    input  logic [XLEN-1:0]    temp_target
);

    next_pc_sel_t       npc_sel;
    logic [XLEN-1:0]    next_pc_c;

    // Map the redirect hook onto the shared next-pc source encoding.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (temp_sel) begin
            npc_sel = NPC_REDIRECT;
        end
    end

    pc_next_mux #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_next_mux (
        .reset     (reset),
        .sel       (npc_sel),
        .pc        (pc),
        .target    (temp_target),
        .next_pc_c (next_pc_c)
    );

    // Program counter register; synchronous reset to the reset vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc_c;
        end
    end

`ifdef FETCH_TRACE_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    // Fetch/redirect bookkeeping and a per-cycle trace line.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'd1;
            if (temp_sel) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            $display("[fetch] cycle=%0d old_pc=%h new_pc=%h %s redirects=%0d",
                     fetch_cnt, pc, next_pc_c,
                     temp_sel ? "REDIRECT" : "SEQ", redirect_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch_proc.sv
// Scoreboard bench for rv32_fetch_proc: stimulus pushes expected pc values
// from a plain-arithmetic reference model; a monitor pops and compares after
// every rising edge.
module tb_rv32_fetch_proc;

    logic        clk;
    logic        reset;
    logic        temp_sel;
    logic [31:0] temp_target;
    logic [31:0] pc;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // Reference model state: pc as an unbounded integer, reduced mod 2^32.
    longint unsigned m_pc;
    bit              m_valid;

    rv32_fetch_proc dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .temp_sel    (temp_sel),
        .temp_target (temp_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge and predict the pc after
    // the following rising edge.
    task automatic step(input logic r, input logic s, input logic [31:0] t,
                        input string nm);
        longint unsigned nxt;
        @(negedge clk);
        reset       = r;
        temp_sel    = s;
        temp_target = t;
        #1;
        if (m_valid) begin
            n_checks++;
            if (pc !== m_pc[31:0]) begin
                n_fail++;
                $display("FAIL comb_path(%s): pc=%h required %h (pc changed between edges)",
                         nm, pc, m_pc[31:0]);
            end
        end
        if (r) begin
            nxt = 64'h0;
        end else if (s) begin
            nxt = (longint'(t) / 4) * 4;
        end else begin
            nxt = (m_pc + 4) % 64'h1_0000_0000;
        end
        m_pc    = nxt;
        m_valid = 1'b1;
        exp_q.push_back(nxt[31:0]);
        name_q.push_back(nm);
    endtask

    // Monitor: one registered pc value per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (pc !== e) begin
                    n_fail++;
                    $display("FAIL %s: pc=%h required %h", nm, pc, e);
                end
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        m_pc        = 0;
        m_valid     = 1'b0;
        reset       = 1'b0;
        temp_sel    = 1'b0;
        temp_target = 32'h0;

        // Reset one cycle, then sequential fetch up to 0x14.
        step(1'b1, 1'b0, 32'h0, "reset");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, "seq_from_reset");

        // Redirect to 0x80 then resume sequentially.
        step(1'b0, 1'b1, 32'h0000_0080, "redirect_80");
        step(1'b0, 1'b0, 32'h0, "seq_after_redirect");
        step(1'b0, 1'b0, 32'h0, "seq_after_redirect");

        // Misaligned target gets masked.
        step(1'b0, 1'b1, 32'h0000_0083, "redirect_mask");
        step(1'b0, 1'b0, 32'h0, "seq_after_mask");

        // Reset beats redirect.
        step(1'b1, 1'b1, 32'h0000_0080, "reset_over_redirect");
        step(1'b0, 1'b0, 32'h0, "seq_after_reset");

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, "redirect_top");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, "seq_wrap");

        // Redirect held for several edges keeps reloading the target.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0000_0200, "redirect_hold");
        step(1'b0, 1'b0, 32'h0, "seq_after_hold");

        // Mid-run reset at pc=0x40, held two edges, then released.
        step(1'b0, 1'b1, 32'h0000_003C, "redirect_3c");
        step(1'b0, 1'b0, 32'h0, "seq_to_40");
        step(1'b1, 1'b0, 32'h0, "midrun_reset");
        step(1'b1, 1'b1, 32'h0000_1234, "reset_held");
        step(1'b0, 1'b0, 32'h0, "seq_after_midrun_reset");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        s;
            logic [31:0] t;
            r = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = $urandom;
            step(r, s, t, "random");
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int unsigned guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            #2;
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
